ccu_serial: RTL and testbench
=============================

CCU_SERIAL -- requirements
Module: ccu_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 2: bits processed per clock cycle.
- WIDTH SHALL be an integer multiple of DIGIT, with 1 <= DIGIT <= WIDTH.
- N = WIDTH/DIGIT.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset; these are the first two ports below.
REQ-004 The block SHALL have these ports:
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high; forces the reset state immediately
- start  input  1  request to begin an operation; sampled on the rising edge
- sub  input  1  operation select: 0 = A+B, 1 = A-B; captured with start
- A  input  WIDTH  operand A, unsigned / two's complement; captured with start
- B  input  WIDTH  operand B; captured with start
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle pulse: result just updated
- sum  output  WIDTH  result, held until the next completion
- cout  output  1  carry out; for subtract, 1 = no borrow
- ovf  output  1  two's-complement signed overflow of the result

Function
REQ-005 The block SHALL implement an FSM with three states.
- IDLE: busy=0, done=0.
- RUN: busy=1, done=0.
- DONE: busy=0, done=1, exactly one cycle.
REQ-006 In IDLE with start=1 at edge k, the block SHALL:
- latch A, B and sub;
- form Bop = B XOR {WIDTH{sub}};
- initialise the carry register to sub and the digit counter to 0;
- enter RUN.
REQ-007 In RUN, each edge SHALL add:
- digit i of A (bits i*DIGIT+DIGIT-1 : i*DIGIT), plus
- digit i of Bop, plus
- the carry register,
storing the DIGIT-bit partial sum into bits of the result shift register and the carry-out into the carry register. Digits are processed LSB digit first.
REQ-008 The block SHALL count digits 0..N-1 with a counter of width max(1, clog2(N)). After the edge that processes digit N-1 (edge k+N), the state SHALL be DONE.
REQ-009 At edge k+N the block SHALL load the outputs:
- sum = full WIDTH result;
- cout = final carry;
- ovf = (A[MSB]==Bop[MSB]) AND (sum[MSB]!=A[MSB]).
REQ-010 Latency SHALL be fixed: done is high in the cycle following edge k+N. The edge after that (k+N+1) SHALL return the FSM to IDLE.
REQ-011 sum, cout and ovf SHALL change only at completion (or reset) and SHALL hold between operations.
REQ-012 start SHALL be ignored in RUN and DONE, and changes to A, B or sub while busy SHALL NOT affect the result.
REQ-013 A start in the IDLE cycle immediately after DONE SHALL be accepted normally; back-to-back throughput is one operation per N+2 cycles.
REQ-014 When DIGIT=WIDTH (N=1), RUN SHALL last exactly one cycle and all rules above SHALL still hold.
REQ-015 Arithmetic SHALL be modulo 2^WIDTH; carries beyond the MSB go only to cout.

Reset
REQ-016 On reset=1, asynchronously and regardless of clk, the block SHALL:
- set the state to IDLE;
- clear busy, done, sum, cout and ovf to 0;
- clear the carry register, digit counter, operand latches and result shift register.
REQ-017 Reset asserted mid-RUN SHALL abort the operation:
- no done pulse;
- outputs remain 0 after reset releases;
- the next start is processed normally.
REQ-018 While reset=1, start SHALL be ignored.

Verification
REQ-019 The bench SHALL cover these directed scenarios (defaults WIDTH=8, DIGIT=2, N=4 unless stated):
- Reset: assert reset, no clk edge -> busy=0, done=0, sum=0, cout=0, ovf=0 immediately.
- Add: A=100, B=27, sub=0, start at edge k -> busy high for cycles k..k+3; done high only after edge k+4; sum=127, cout=0, ovf=0.
- Overflow/carry: A=100, B=100 add -> sum=200, cout=0, ovf=1. A=200, B=100 add -> sum=44, cout=1, ovf=0.
- Subtract: A=5, B=7, sub=1 -> sum=254, cout=0, ovf=0. A=7, B=5, sub=1 -> sum=2, cout=1, ovf=0.
- Busy protection and abort:
  - Start with A=10, B=20, then at edge k+1 drive start=1, A=99, B=99 -> single done, sum=30.
  - Assert reset at edge k+2 of a new operation -> no done, outputs 0.
- Boundary: WIDTH=8, DIGIT=8, A=255, B=1 add -> done after edge k+1; sum=0, cout=1, ovf=0. Back-to-back start in the cycle after DONE is accepted.

Source files
------------

// File: rtl/ccu_serial.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first; done pulses N+1 cycles after start.
// No backpressure: start is taken only in IDLE, and results hold until the next completion.
module ccu_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
   logic             a_msb, b_msb, carry, last;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   dsum;

   // Operand registers shift right each RUN cycle so the low digit is always the current one.
   assign dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
   assign res_nxt = (res_sh >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
   assign last    = (cnt == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_sh   <= A;
               b_sh   <= B ^ {WIDTH{sub}};
               a_msb  <= A[WIDTH-1];
               b_msb  <= B[WIDTH-1] ^ sub;
               carry  <= sub;
               cnt    <= '0;
               res_sh <= '0;
            end
            RUN: begin
               a_sh   <= a_sh >> DIGIT;
               b_sh   <= b_sh >> DIGIT;
               res_sh <= res_nxt;
               carry  <= dsum[DIGIT];
               cnt    <= cnt + 1'b1;
               if (last) begin
                  sum  <= res_nxt;
                  cout <= dsum[DIGIT];
                  ovf  <= (a_msb == b_msb) && (res_nxt[WIDTH-1] != a_msb);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ccu_serial.sv
// Bench for ccu_serial: dut0 is WIDTH=8/DIGIT=2, dut1 is WIDTH=8/DIGIT=8.
// Expected results are queued at issue time and popped by a monitor on each done pulse.
module tb_ccu_serial;
   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start0 = 1'b0, sub0 = 1'b0, start1 = 1'b0, sub1 = 1'b0;
   logic [7:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
   logic       busy0, done0, cout0, ovf0, busy1, done1, cout1, ovf1;
   logic [7:0] sum0, sum1;

   int   cyc = 0;
   int   tests = 0, fails = 0;
   int   ndone0 = 0, ndone1 = 0, pushed0 = 0, pushed1 = 0;
   exp_t q0[$];
   exp_t q1[$];

   ccu_serial #(.WIDTH(8), .DIGIT(2)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .sub(sub0), .A(A0), .B(B0),
      .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0));

   ccu_serial #(.WIDTH(8), .DIGIT(8)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .sub(sub1), .A(A1), .B(B1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views of the operands.
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
      exp_t e;
      int ua = a, ub = b, sa = $signed(a), sb = $signed(b), r, sr;
      if (s) begin
         r      = ua - ub;
         sr     = sa - sb;
         e.cout = (ua >= ub);
      end else begin
         r      = ua + ub;
         sr     = sa + sb;
         e.cout = (r > 255);
      end
      e.sum = 8'(r);
      e.ovf = (sr > 127) || (sr < -128);
      e.cyc = 0;
      return e;
   endfunction

   task automatic mon_check(input int u, input logic [7:0] s, input logic c, input logic o);
      exp_t e;
      if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
         tests++;
         fails++;
         $display("FAIL dut%0d unexpected done: sum=%0d at cycle %0d, no operation pending", u, s, cyc);
         return;
      end
      e = (u == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("dut%0d sum", u), s, e.sum);
      check($sformatf("dut%0d cout", u), c, e.cout);
      check($sformatf("dut%0d ovf", u), o, e.ovf);
      check($sformatf("dut%0d done cycle", u), cyc, e.cyc);
   endtask

   always @(negedge clk) begin
      if (done0 === 1'b1) begin
         ndone0++;
         mon_check(0, sum0, cout0, ovf0);
      end
      if (done1 === 1'b1) begin
         ndone1++;
         mon_check(1, sum1, cout1, ovf1);
      end
   end

   // Waits for IDLE, presents start for one edge (edge kc), then scrambles the operands.
   task automatic issue(input int u, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input bit push, output int kc);
      exp_t e;
      bit   ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (u == 0 ? (!busy0 && !done0) : (!busy1 && !done1)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL dut%0d idle wait: still busy after 60 cycles", u);
         kc = -1;
         return;
      end
      if (u == 0) begin start0 = 1'b1; A0 = a; B0 = b; sub0 = s; end
      else        begin start1 = 1'b1; A1 = a; B1 = b; sub1 = s; end
      kc = cyc + 1;
      if (push) begin
         e     = model(a, b, s);
         e.cyc = kc + ((u == 0) ? 4 : 1);
         if (u == 0) begin q0.push_back(e); pushed0++; end
         else        begin q1.push_back(e); pushed1++; end
      end
      @(posedge clk);
      #1;
      if (u == 0) begin start0 = 1'b0; A0 = 8'($urandom); B0 = 8'($urandom); sub0 = 1'($urandom); end
      else        begin start1 = 1'b0; A1 = 8'($urandom); B1 = 8'($urandom); sub1 = 1'($urandom); end
   endtask

   initial begin
      int  k, prev;
      bit  seen;

      #1 reset = 1'b1;
      #1;
      check("reset busy", busy0, 0);
      check("reset done", done0, 0);
      check("reset sum", sum0, 0);
      check("reset cout", cout0, 0);
      check("reset ovf", ovf0, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      issue(0, 8'd100, 8'd27, 1'b0, 1'b1, k);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("busy during run %0d", i), busy0, 1);
         check($sformatf("no done during run %0d", i), done0, 0);
         @(posedge clk);
         #1;
      end
      check("busy after run", busy0, 0);
      check("done after run", done0, 1);

      issue(0, 8'd100, 8'd100, 1'b0, 1'b1, k);
      issue(0, 8'd200, 8'd100, 1'b0, 1'b1, k);
      issue(0, 8'd5, 8'd7, 1'b1, 1'b1, k);
      issue(0, 8'd7, 8'd5, 1'b1, 1'b1, k);

      // Start and operands churn while busy; only the first operation may complete.
      issue(0, 8'd10, 8'd20, 1'b0, 1'b1, k);
      start0 = 1'b1; A0 = 8'd99; B0 = 8'd99; sub0 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done0) begin
            seen = 1'b1;
            break;
         end
      end
      start0 = 1'b0;
      check("busy-protect done seen", seen, 1);
      repeat (8) @(posedge clk);
      #1;

      issue(0, 8'd50, 8'd60, 1'b0, 1'b0, k);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort busy", busy0, 0);
      check("abort done", done0, 0);
      check("abort sum", sum0, 0);
      check("abort cout", cout0, 0);
      check("abort ovf", ovf0, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("post-abort sum", sum0, 0);
      check("post-abort busy", busy0, 0);
      issue(0, 8'd3, 8'd4, 1'b0, 1'b1, k);

      prev = -1;
      for (int i = 0; i < 40; i++) begin
         issue(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, k);
         if (prev >= 0) check("dut0 back-to-back spacing", k - prev, 6);
         prev = k;
      end

      issue(1, 8'd255, 8'd1, 1'b0, 1'b1, k);
      prev = k;
      for (int i = 0; i < 15; i++) begin
         issue(1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, k);
         check("dut1 back-to-back spacing", k - prev, 3);
         prev = k;
      end

      for (int i = 0; i < 200; i++) begin
         if (q0.size() == 0 && q1.size() == 0) break;
         @(posedge clk);
      end
      repeat (4) @(posedge clk);
      #1;
      check("dut0 pending results", q0.size(), 0);
      check("dut1 pending results", q1.size(), 0);
      check("dut0 done count", ndone0, pushed0);
      check("dut1 done count", ndone1, pushed1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
